// File: rtl/nx_indirect_access_mem_arb_pkg.sv
// Types and limits shared by the indirect-access memory arbiter.
// The arbiter top includes an elaboration-time check of HW_BURST_MAX.
// That check calls burst_max_ok() from this package.
// This package has no ports.
package nx_mem_typePKG;

  // Who owns the memory port this cycle. It selects the memory mux and is
  // also useful as a debug probe.
  typedef enum logic [1:0] {OWN_NONE, OWN_SW, OWN_HW} owner_e;

  localparam int unsigned STARVE_W         = 8;
  localparam int unsigned STALL_W          = 16;
  localparam int unsigned HW_BURST_MIN     = 1;
  localparam int unsigned HW_BURST_LIM     = (1 << STARVE_W) - 1;
  localparam int unsigned HW_BURST_MAX_DEF = 8;

  // The burst limit has to fit in the starvation counter, and it must be
  // non-zero so that hardware gets at least one access.
  function automatic bit burst_max_ok(input int unsigned v);
    return (v >= HW_BURST_MIN) && (v <= HW_BURST_LIM);
  endfunction

endpackage

// File: rtl/nx_indirect_access_mem_arb_if.sv
// Bus bundle around the arbiter. It carries three groups of signals:
//   - the controller (sw_*) port,
//   - the hardware requester (hw_*) port,
//   - the physical RAM (mem_*) port.
// It also carries the stall statistic.
// Modports:
//   - slave is the arbiter's view.
//   - master is everything around the arbiter (controller, datapath, RAM).
interface nx_indirect_access_mem_arb_if #(
  parameter int unsigned N_ADDR_BITS = 9,
  parameter int unsigned N_DATA_BITS = 96
);
  logic                   sw_cs, sw_ce, sw_we, yield, reset, grant;
  logic [N_ADDR_BITS-1:0] sw_add;
  logic [N_DATA_BITS-1:0] sw_wdat, sw_rdat;
  logic                   hw_req, hw_we, hw_gnt, hw_rvld;
  logic [N_ADDR_BITS-1:0] hw_add;
  logic [N_DATA_BITS-1:0] hw_wdat, hw_rdat;
  logic                   mem_cs, mem_ce, mem_we;
  logic [N_ADDR_BITS-1:0] mem_add;
  logic [N_DATA_BITS-1:0] mem_wdat, mem_rdat;
  logic [15:0]            hw_stall_cnt;

  modport slave (
    input  sw_cs, sw_ce, sw_we, sw_add, sw_wdat, yield, reset,
           hw_req, hw_we, hw_add, hw_wdat, mem_rdat,
    output grant, sw_rdat, hw_gnt, hw_rdat, hw_rvld,
           mem_cs, mem_ce, mem_we, mem_add, mem_wdat, hw_stall_cnt
  );

  modport master (
    output sw_cs, sw_ce, sw_we, sw_add, sw_wdat, yield, reset,
           hw_req, hw_we, hw_add, hw_wdat, mem_rdat,
    input  grant, sw_rdat, hw_gnt, hw_rdat, hw_rvld,
           mem_cs, mem_ce, mem_we, mem_add, mem_wdat, hw_stall_cnt
  );
endinterface

// File: rtl/nx_indirect_access_mem_arb_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear has priority over increment.
// Ports:
//   - clk, rst_n: clock and asynchronous active-low reset.
//   - clr_i: clear to 0.
//   - inc_i: count up; the count stops at MAX.
//   - cnt_o: current count.
module nx_sat_counter #(
  parameter int unsigned W   = 8,
  parameter logic [W-1:0] MAX = {W{1'b1}}
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                    cnt_d = '0;
    else if (inc_i && cnt_q != MAX) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/nx_indirect_access_mem_arb.sv
// Arbiter that shares one single-port RAM between two requesters:
//   - the indirect access controller (sw_*),
//   - one hardware datapath requester (hw_*).
// Hardware wins by default. Software wins in any of these cases:
//   - hardware is idle,
//   - the controller yields,
//   - the controller is in a reset/init sweep,
//   - hardware has won HW_BURST_MAX times in a row against a pending
//     software request.
// Ports:
//   - clk, rst_n: clock and asynchronous active-low reset.
//   - bus: the slave modport, carrying the sw/hw/mem groups and
//     hw_stall_cnt.
module nx_indirect_access_mem_arb
  import nx_mem_typePKG::*;
#(
  parameter int unsigned N_ADDR_BITS  = 9,
  parameter int unsigned N_DATA_BITS  = 96,
  parameter int unsigned HW_BURST_MAX = HW_BURST_MAX_DEF
) (
  input logic                         clk,
  input logic                         rst_n,
  nx_indirect_access_mem_arb_if.slave bus
);
  if (!burst_max_ok(HW_BURST_MAX)) begin : g_bad_burst
    $error("HW_BURST_MAX must be within 1..255");
  end

  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(HW_BURST_MAX);

  logic                   lock_q, lock_d, hw_rd_q;
  logic                   lock_eff, sw_win, hw_win;
  logic [STARVE_W-1:0]    starve_q;
  logic [STALL_W-1:0]     stall_cnt;
  owner_e                 own;
  logic                   mem_we, mem_ce;
  logic [N_ADDR_BITS-1:0] mem_add;
  logic [N_DATA_BITS-1:0] mem_wdat;

  // The lock only matters while the sweep is still running. Gating it with
  // reset lets hardware in during the same cycle that reset falls, one cycle
  // before lock_q itself clears.
  assign lock_eff = lock_q & bus.reset;
  assign sw_win   = rst_n & bus.sw_cs & (lock_eff | bus.reset | bus.yield |
                    ~bus.hw_req | (starve_q == STARVE_MAX));
  assign hw_win   = rst_n & bus.hw_req & ~sw_win & ~lock_eff;

  always_comb begin
    own = OWN_NONE;
    if (sw_win)      own = OWN_SW;
    else if (hw_win) own = OWN_HW;
  end

  // With no owner, mem_add and mem_wdat idle on the hardware values so that
  // the address bus does not toggle needlessly.
  always_comb begin
    mem_we   = 1'b0;
    mem_ce   = 1'b0;
    mem_add  = bus.hw_add;
    mem_wdat = bus.hw_wdat;
    case (own)
      OWN_SW: begin
        mem_we   = bus.sw_we;
        mem_ce   = bus.sw_ce;
        mem_add  = bus.sw_add;
        mem_wdat = bus.sw_wdat;
      end
      OWN_HW:  mem_we = bus.hw_we;
      default: ;
    endcase
  end

  assign bus.grant    = (own == OWN_SW);
  assign bus.hw_gnt   = (own == OWN_HW);
  assign bus.mem_cs   = (own != OWN_NONE);
  assign bus.mem_we   = mem_we;
  assign bus.mem_ce   = mem_ce;
  assign bus.mem_add  = mem_add;
  assign bus.mem_wdat = mem_wdat;
  assign bus.sw_rdat  = bus.mem_rdat;
  assign bus.hw_rdat  = bus.mem_rdat;
  assign bus.hw_rvld  = hw_rd_q;

  // The lock is released as soon as the sweep ends, or when the controller
  // drops its request (an abort or error mid-sweep).
  always_comb begin
    lock_d = lock_q;
    if (!bus.reset || !bus.sw_cs) lock_d = 1'b0;
    else if (sw_win)              lock_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q  <= 1'b0;
      hw_rd_q <= 1'b0;
    end else begin
      lock_q  <= lock_d;
      hw_rd_q <= hw_win & ~bus.hw_we;
    end
  end

  // Counts hardware wins against a pending software request.
  nx_sat_counter #(.W(STARVE_W), .MAX(STARVE_MAX)) u_starve (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (sw_win | ~bus.sw_cs),
    .inc_i (hw_win & bus.sw_cs),
    .cnt_o (starve_q)
  );

  // Counts refused hardware cycles. Only reset clears it.
  nx_sat_counter #(.W(STALL_W)) u_stall (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (1'b0),
    .inc_i (bus.hw_req & ~hw_win),
    .cnt_o (stall_cnt)
  );

  assign bus.hw_stall_cnt = stall_cnt;
endmodule
